// File: rtl/vga_ball_display.sv
// vga_ball_display: 640x480 @ 60 Hz raster generator (50 MHz clk, 2 clk per pixel)
// drawing a solid background and one white filled ball. Avalon-MM writes land in
// pending registers that are copied to the display registers once per frame, at the
// start of vertical blanking, so the visible image never tears.
module vga_ball_display #(
   parameter int unsigned BALL_R = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       chipselect,
   input  logic       write,
   input  logic       read,
   input  logic [2:0] address,
   input  logic [7:0] writedata,
   output logic [7:0] readdata,
   output logic [7:0] vga_r,
   output logic [7:0] vga_g,
   output logic [7:0] vga_b,
   output logic       vga_clk,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic       vga_blank_n,
   output logic       vga_sync_n
);

   // Counter, coordinate, colour and distance widths
   localparam int unsigned HW = 11;
   localparam int unsigned VW = 10;
   localparam int unsigned PW = 10;
   localparam int unsigned CW = 8;
   localparam int unsigned FW = 8;
   localparam int unsigned DW = 11;
   localparam int unsigned SW = 22;

   // Horizontal timing in clk ticks (two ticks per pixel)
   localparam int unsigned H_TOTAL    = 1600;
   localparam int unsigned H_ACTIVE   = 1280;
   localparam int unsigned H_SYNC_BEG = 1312;
   localparam int unsigned H_SYNC_END = 1503;

   // Vertical timing in lines
   localparam int unsigned V_TOTAL    = 525;
   localparam int unsigned V_ACTIVE   = 480;
   localparam int unsigned V_SYNC_BEG = 490;
   localparam int unsigned V_SYNC_END = 491;

   // Register indices
   localparam logic [2:0] A_BG_R = 3'd0;
   localparam logic [2:0] A_BG_G = 3'd1;
   localparam logic [2:0] A_BG_B = 3'd2;
   localparam logic [2:0] A_X_LO = 3'd3;
   localparam logic [2:0] A_X_HI = 3'd4;
   localparam logic [2:0] A_Y_LO = 3'd5;
   localparam logic [2:0] A_Y_HI = 3'd6;
   localparam logic [2:0] A_FCNT = 3'd7;

   // Reset image: dark blue background, ball centred
   localparam logic [CW-1:0] BG_R_RST = 8'h00;
   localparam logic [CW-1:0] BG_G_RST = 8'h00;
   localparam logic [CW-1:0] BG_B_RST = 8'h80;
   localparam logic [PW-1:0] X_RST    = 10'd320;
   localparam logic [PW-1:0] Y_RST    = 10'd240;

   localparam logic signed [SW-1:0] R_SQ = $signed(SW'(BALL_R * BALL_R));

   // Raster counters
   logic [HW-1:0] hcount_q, hcount_d;
   logic [VW-1:0] vcount_q, vcount_d;
   logic [FW-1:0] frame_count_q, frame_count_d;
   logic [CW-1:0] readdata_q, readdata_d;

   // Pending (host-visible) registers
   logic [CW-1:0] pend_r_q, pend_r_d;
   logic [CW-1:0] pend_g_q, pend_g_d;
   logic [CW-1:0] pend_b_q, pend_b_d;
   logic [PW-1:0] pend_x_q, pend_x_d;
   logic [PW-1:0] pend_y_q, pend_y_d;

   // Display registers, stable for a whole frame
   logic [CW-1:0] disp_r_q, disp_r_d;
   logic [CW-1:0] disp_g_q, disp_g_d;
   logic [CW-1:0] disp_b_q, disp_b_d;
   logic [PW-1:0] disp_x_q, disp_x_d;
   logic [PW-1:0] disp_y_q, disp_y_d;

   // Decoded timing conditions
   logic line_end_c;
   logic frame_end_c;
   logic latch_c;
   logic h_active_c;
   logic v_active_c;
   logic active_c;
   logic h_sync_c;
   logic v_sync_c;
   logic wr_en_c;
   logic rd_en_c;

   // Ball distance datapath
   logic [PW-1:0]          px_c;
   logic signed [DW-1:0]   dx_c;
   logic signed [DW-1:0]   dy_c;
   logic signed [SW-1:0]   dx_ext_c;
   logic signed [SW-1:0]   dy_ext_c;
   logic signed [SW-1:0]   dx_sq_c;
   logic signed [SW-1:0]   dy_sq_c;
   logic signed [SW-1:0]   dist_c;
   logic                   inside_c;

   // Timing decode from the counters
   always_comb begin
      line_end_c  = (hcount_q == HW'(H_TOTAL - 1));
      frame_end_c = (vcount_q == VW'(V_TOTAL - 1));
      latch_c     = line_end_c && (vcount_q == VW'(V_ACTIVE - 1));
      h_active_c  = (hcount_q < HW'(H_ACTIVE));
      v_active_c  = (vcount_q < VW'(V_ACTIVE));
      active_c    = h_active_c && v_active_c;
      h_sync_c    = (hcount_q >= HW'(H_SYNC_BEG)) && (hcount_q <= HW'(H_SYNC_END));
      v_sync_c    = (vcount_q >= VW'(V_SYNC_BEG)) && (vcount_q <= VW'(V_SYNC_END));
      wr_en_c     = chipselect && write;
      rd_en_c     = chipselect && read;
   end

   // Horizontal / vertical counter advance
   always_comb begin
      hcount_d = hcount_q + HW'(1);
      vcount_d = vcount_q;
      if (line_end_c) begin
         hcount_d = '0;
         if (frame_end_c) begin
            vcount_d = '0;
         end else begin
            vcount_d = vcount_q + VW'(1);
         end
      end
   end

   // Host writes into the pending registers
   always_comb begin
      pend_r_d = pend_r_q;
      pend_g_d = pend_g_q;
      pend_b_d = pend_b_q;
      pend_x_d = pend_x_q;
      pend_y_d = pend_y_q;
      if (wr_en_c) begin
         case (address)
            A_BG_R:  pend_r_d = writedata;
            A_BG_G:  pend_g_d = writedata;
            A_BG_B:  pend_b_d = writedata;
            A_X_LO:  pend_x_d = {pend_x_q[PW-1:8], writedata};
            A_X_HI:  pend_x_d = {writedata[1:0], pend_x_q[7:0]};
            A_Y_LO:  pend_y_d = {pend_y_q[PW-1:8], writedata};
            A_Y_HI:  pend_y_d = {writedata[1:0], pend_y_q[7:0]};
            default: ;
         endcase
      end
   end

   // Frame latch: display takes the pre-write pending values, frame counter advances
   always_comb begin
      disp_r_d      = disp_r_q;
      disp_g_d      = disp_g_q;
      disp_b_d      = disp_b_q;
      disp_x_d      = disp_x_q;
      disp_y_d      = disp_y_q;
      frame_count_d = frame_count_q;
      if (latch_c) begin
         disp_r_d      = pend_r_q;
         disp_g_d      = pend_g_q;
         disp_b_d      = pend_b_q;
         disp_x_d      = pend_x_q;
         disp_y_d      = pend_y_q;
         frame_count_d = frame_count_q + FW'(1);
      end
   end

   // Read mux; readdata holds between reads
   always_comb begin
      readdata_d = readdata_q;
      if (rd_en_c) begin
         case (address)
            A_BG_R:  readdata_d = pend_r_q;
            A_BG_G:  readdata_d = pend_g_q;
            A_BG_B:  readdata_d = pend_b_q;
            A_X_LO:  readdata_d = pend_x_q[7:0];
            A_X_HI:  readdata_d = {6'b0, pend_x_q[PW-1:8]};
            A_Y_LO:  readdata_d = pend_y_q[7:0];
            A_Y_HI:  readdata_d = {6'b0, pend_y_q[PW-1:8]};
            A_FCNT:  readdata_d = frame_count_q;
            default: readdata_d = readdata_q;
         endcase
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hcount_q      <= '0;
         vcount_q      <= '0;
         frame_count_q <= '0;
         readdata_q    <= '0;
         pend_r_q      <= BG_R_RST;
         pend_g_q      <= BG_G_RST;
         pend_b_q      <= BG_B_RST;
         pend_x_q      <= X_RST;
         pend_y_q      <= Y_RST;
         disp_r_q      <= BG_R_RST;
         disp_g_q      <= BG_G_RST;
         disp_b_q      <= BG_B_RST;
         disp_x_q      <= X_RST;
         disp_y_q      <= Y_RST;
      end else begin
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         frame_count_q <= frame_count_d;
         readdata_q    <= readdata_d;
         pend_r_q      <= pend_r_d;
         pend_g_q      <= pend_g_d;
         pend_b_q      <= pend_b_d;
         pend_x_q      <= pend_x_d;
         pend_y_q      <= pend_y_d;
         disp_r_q      <= disp_r_d;
         disp_g_q      <= disp_g_d;
         disp_b_q      <= disp_b_d;
         disp_x_q      <= disp_x_d;
         disp_y_q      <= disp_y_d;
      end
   end

   // Signed distance from the ball centre; squares cannot overflow 22 bits
   always_comb begin
      px_c     = hcount_q[HW-1:1];
      dx_c     = $signed({1'b0, px_c}) - $signed({1'b0, disp_x_q});
      dy_c     = $signed({1'b0, vcount_q}) - $signed({1'b0, disp_y_q});
      dx_ext_c = {{(SW - DW){dx_c[DW-1]}}, dx_c};
      dy_ext_c = {{(SW - DW){dy_c[DW-1]}}, dy_c};
      dx_sq_c  = dx_ext_c * dx_ext_c;
      dy_sq_c  = dy_ext_c * dy_ext_c;
      dist_c   = dx_sq_c + dy_sq_c;
      inside_c = (dist_c <= R_SQ);
   end

   // Pixel colour: black in blanking, white inside the ball, background elsewhere
   always_comb begin
      vga_r = '0;
      vga_g = '0;
      vga_b = '0;
      if (active_c) begin
         if (inside_c) begin
            vga_r = 8'hFF;
            vga_g = 8'hFF;
            vga_b = 8'hFF;
         end else begin
            vga_r = disp_r_q;
            vga_g = disp_g_q;
            vga_b = disp_b_q;
         end
      end
   end

   assign vga_clk     = hcount_q[0];
   assign vga_hs      = !h_sync_c;
   assign vga_vs      = !v_sync_c;
   assign vga_blank_n = active_c;
   assign vga_sync_n  = 1'b0;
   assign readdata    = readdata_q;

endmodule

// File: tb/tb_vga_ball_display.sv
// Bench for vga_ball_display: a cycle-level behavioural model of raster position,
// pending/display registers and frame counter, checked against the DUT outputs.
// Long vertical stretches are skipped by forcing the raster counters, then the
// model re-synchronises on the next hsync trailing edge.
module tb_vga_ball_display;
   localparam int BALL_R = 16;

   logic       clk;
   logic       reset_n;
   logic       chipselect;
   logic       write;
   logic       read;
   logic [2:0] address;
   logic [7:0] writedata;
   logic [7:0] readdata;
   logic [7:0] vga_r;
   logic [7:0] vga_g;
   logic [7:0] vga_b;
   logic       vga_clk;
   logic       vga_hs;
   logic       vga_vs;
   logic       vga_blank_n;
   logic       vga_sync_n;

   vga_ball_display #(.BALL_R(BALL_R)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .chipselect  (chipselect),
      .write       (write),
      .read        (read),
      .address     (address),
      .writedata   (writedata),
      .readdata    (readdata),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .vga_clk     (vga_clk),
      .vga_hs      (vga_hs),
      .vga_vs      (vga_vs),
      .vga_blank_n (vga_blank_n),
      .vga_sync_n  (vga_sync_n)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Model state; m_h < 0 means raster position unknown
   int m_h, m_v, m_fc, m_rd;
   int p_r, p_g, p_b, p_x, p_y;
   int d_r, d_g, d_b, d_x, d_y;

   logic [10:0] force_h;
   logic [9:0]  force_v;

   task automatic model_reset();
      m_h = 0; m_v = 0; m_fc = 0; m_rd = 0;
      p_r = 0; p_g = 0; p_b = 128; p_x = 320; p_y = 240;
      d_r = 0; d_g = 0; d_b = 128; d_x = 320; d_y = 240;
   endtask

   function automatic int reg_val(input int a);
      case (a)
         0: return p_r;
         1: return p_g;
         2: return p_b;
         3: return p_x % 256;
         4: return p_x / 256;
         5: return p_y % 256;
         6: return p_y / 256;
         default: return m_fc;
      endcase
   endfunction

   task automatic latch_model();
      d_r = p_r; d_g = p_g; d_b = p_b; d_x = p_x; d_y = p_y;
      m_fc = (m_fc + 1) % 256;
   endtask

   // One clock edge: model follows the inputs that were stable at the edge
   task automatic step();
      logic rst, cs, wr, rd;
      logic [2:0] a;
      int wd;
      rst = reset_n; cs = chipselect; wr = write; rd = read;
      a = address; wd = int'(writedata);
      @(posedge clk);
      if (rst !== 1'b1) begin
         model_reset();
      end else begin
         if (cs && rd) m_rd = reg_val(int'(a));
         if (m_h == 1599 && m_v == 479) latch_model();
         if (cs && wr) begin
            case (a)
               3'd0: p_r = wd;
               3'd1: p_g = wd;
               3'd2: p_b = wd;
               3'd3: p_x = (p_x / 256) * 256 + wd;
               3'd4: p_x = (wd % 4) * 256 + p_x % 256;
               3'd5: p_y = (p_y / 256) * 256 + wd;
               3'd6: p_y = (wd % 4) * 256 + p_y % 256;
               default: ;
            endcase
         end
         if (m_h >= 0) begin
            if (m_h == 1599) begin
               m_h = 0;
               m_v = (m_v == 524) ? 0 : m_v + 1;
            end else begin
               m_h = m_h + 1;
            end
         end
      end
      #1;
   endtask

   function automatic logic [28:0] exp_vec();
      int px, dx, dy;
      logic [23:0] rgb;
      logic act;
      act = (m_h < 1280) && (m_v < 480);
      rgb = 24'h0;
      if (act) begin
         px = m_h / 2;
         dx = px - d_x;
         dy = m_v - d_y;
         if (dx * dx + dy * dy <= BALL_R * BALL_R) rgb = 24'hFFFFFF;
         else rgb = {8'(d_r), 8'(d_g), 8'(d_b)};
      end
      return {rgb, !(m_h >= 1312 && m_h <= 1503), !(m_v >= 490 && m_v <= 491),
              act, 1'(m_h % 2), 1'b0};
   endfunction

   function automatic logic [28:0] act_vec();
      return {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_clk, vga_sync_n};
   endfunction

   // Step until the model reaches (th, tv), comparing every cycle against the model
   task automatic run_to(input string name, input int th, input int tv);
      int errs = 0;
      int n = 0;
      int fh = 0;
      int fv = 0;
      logic [28:0] e;
      logic [28:0] a;
      logic [28:0] fe = '0;
      logic [28:0] fa = '0;
      while (!(m_h == th && m_v == tv) && n < 5000) begin
         step();
         n++;
         e = exp_vec();
         a = act_vec();
         if (a !== e) begin
            if (errs == 0) begin fh = m_h; fv = m_v; fe = e; fa = a; end
            errs++;
         end
      end
      tests++;
      if (errs != 0 || n >= 5000) begin
         fails++;
         $display("FAIL %s: %0d bad cycles of %0d, first at h=%0d v=%0d got %h expected %h",
                  name, errs, n, fh, fv, fa, fe);
      end
   endtask

   // Jump the raster to hcount~1300 of line v, then resync the model on hsync release
   task goto_line(input int v);
      int n;
      force_h = 11'd1300;
      force_v = 10'(v);
      @(negedge clk);
      force dut.hcount_q = force_h;
      force dut.vcount_q = force_v;
      @(posedge clk);
      #1;
      release dut.hcount_q;
      release dut.vcount_q;
      n = 0;
      while (vga_hs !== 1'b0 && n < 400) begin @(posedge clk); #1; n++; end
      while (vga_hs !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
      m_h = 1504;
      m_v = v;
      tests++;
      if (n >= 400) begin
         fails++;
         m_h = -100;
         $display("FAIL goto_line_%0d: hsync release not seen, waited %0d cycles", v, n);
      end
   endtask

   // Pass exactly one frame latch quickly; raster position is unknown afterwards
   task frame_jump();
      force_h = 11'd1590;
      force_v = 10'd479;
      @(negedge clk);
      force dut.hcount_q = force_h;
      force dut.vcount_q = force_v;
      @(posedge clk);
      #1;
      release dut.hcount_q;
      release dut.vcount_q;
      repeat (20) @(posedge clk);
      #1;
      latch_model();
      m_h = -100;
   endtask

   task automatic av_write(input int a, input int d);
      chipselect = 1'b1; write = 1'b1; address = 3'(a); writedata = 8'(d);
      step();
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic av_read(input int a);
      chipselect = 1'b1; read = 1'b1; address = 3'(a);
      step();
      chipselect = 1'b0; read = 1'b0;
   endtask

   task automatic check_rgb(input string name, input logic [23:0] exp);
      tests++;
      if ({vga_r, vga_g, vga_b} !== exp) begin
         fails++;
         $display("FAIL %s: rgb got %h expected %h", name, {vga_r, vga_g, vga_b}, exp);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
      address = 3'd0; writedata = 8'd0;
      repeat (3) step();
      check_rgb("reset_rgb", 24'h000080);
      tests++;
      if ({vga_hs, vga_vs, vga_blank_n, vga_clk, vga_sync_n} !== 5'b11100) begin
         fails++;
         $display("FAIL reset_sync: hs/vs/blank/clk/sync got %b expected 11100",
                  {vga_hs, vga_vs, vga_blank_n, vga_clk, vga_sync_n});
      end
      tests++;
      if (readdata !== 8'h00) begin
         fails++;
         $display("FAIL reset_readdata: got %h expected 00", readdata);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_timing();
      int errs = 0;
      int hs_low = 0;
      int bl_hi = 0;
      int vs_low = 0;
      int n = 0;
      for (int i = 0; i < 3200; i++) begin
         step();
         if (act_vec() !== exp_vec()) errs++;
         if (vga_hs === 1'b0) hs_low++;
         if (vga_blank_n === 1'b1) bl_hi++;
      end
      tests++;
      if (errs != 0) begin fails++; $display("FAIL timing_scan: %0d bad cycles of 3200", errs); end
      tests++;
      if (hs_low != 384) begin fails++; $display("FAIL hsync_width: got %0d low cycles in 2 lines expected 384", hs_low); end
      tests++;
      if (bl_hi != 2560) begin fails++; $display("FAIL blank_width: got %0d active cycles in 2 lines expected 2560", bl_hi); end
      goto_line(489);
      while (!(m_h == 0 && m_v == 492) && n < 5000) begin
         step();
         n++;
         if (vga_vs === 1'b0) vs_low++;
         if (act_vec() !== exp_vec()) errs++;
      end
      tests++;
      if (vs_low != 3200 || errs != 0) begin
         fails++;
         $display("FAIL vsync_width: got %0d low cycles expected 3200, %0d bad cycles", vs_low, errs);
      end
   endtask

   task automatic test_defaults();
      goto_line(239);
      run_to("def_line240", 640, 240);
      check_rgb("def_centre", 24'hFFFFFF);
      run_to("def_line240b", 672, 240);
      check_rgb("def_right_edge_in", 24'hFFFFFF);
      run_to("def_line240c", 674, 240);
      check_rgb("def_right_edge_out", 24'h000080);
      goto_line(255);
      run_to("def_line256", 640, 256);
      check_rgb("def_bottom_edge_in", 24'hFFFFFF);
      run_to("def_line257", 640, 257);
      check_rgb("def_bottom_edge_out", 24'h000080);
   endtask

   task automatic test_write_timing();
      goto_line(99);
      run_to("wt_to100", 0, 100);
      av_write(0, 8'h55);
      run_to("wt_line100", 0, 101);
      check_rgb("wt_same_frame", 24'h000080);
      av_read(0);
      tests++;
      if (readdata !== 8'h55) begin fails++; $display("FAIL wt_read: got %h expected 55", readdata); end
      repeat (3) step();
      tests++;
      if (readdata !== 8'h55) begin fails++; $display("FAIL wt_read_hold: got %h expected 55", readdata); end
      goto_line(479);
      run_to("wt_latch", 0, 480);
      goto_line(524);
      run_to("wt_to_frame", 0, 0);
      check_rgb("wt_next_frame", 24'h550080);
      run_to("wt_line0", 0, 1);
   endtask

   task automatic test_latch_write();
      goto_line(479);
      run_to("lw_to_latch", 1599, 479);
      av_write(3, 8'h10);
      goto_line(239);
      run_to("lw_old_a", 544, 240);
      check_rgb("lw_old_frame_new_x", 24'h550080);
      run_to("lw_old_b", 640, 240);
      check_rgb("lw_old_frame_old_x", 24'hFFFFFF);
      goto_line(479);
      run_to("lw_latch2", 0, 480);
      goto_line(239);
      run_to("lw_new_a", 544, 240);
      check_rgb("lw_new_frame_new_x", 24'hFFFFFF);
      run_to("lw_new_b", 640, 240);
      check_rgb("lw_new_frame_old_x", 24'h550080);
      av_read(3);
      tests++;
      if (readdata !== 8'h10) begin fails++; $display("FAIL lw_read_xlo: got %h expected 10", readdata); end
   endtask

   task automatic test_frame_count();
      int start;
      start = m_fc;
      av_read(7);
      tests++;
      if (readdata !== 8'(start)) begin fails++; $display("FAIL fc_start: got %0d expected %0d", readdata, start); end
      frame_jump();
      av_read(7);
      tests++;
      if (readdata !== 8'((start + 1) % 256)) begin
         fails++; $display("FAIL fc_plus1: got %0d expected %0d", readdata, (start + 1) % 256);
      end
      repeat (255) frame_jump();
      av_read(7);
      tests++;
      if (readdata !== 8'(start)) begin fails++; $display("FAIL fc_wrap: got %0d expected %0d", readdata, start); end
   endtask

   task automatic test_reset_midframe();
      goto_line(299);
      run_to("rm_to300", 600, 300);
      av_write(1, 8'h77);
      run_to("rm_to700", 700, 300);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      check_rgb("rm_rgb", 24'h000080);
      tests++;
      if ({vga_hs, vga_vs, vga_blank_n, vga_clk} !== 4'b1110) begin
         fails++;
         $display("FAIL rm_sync: hs/vs/blank/clk got %b expected 1110", {vga_hs, vga_vs, vga_blank_n, vga_clk});
      end
      run_to("rm_line0", 1312, 0);
      tests++;
      if (vga_hs !== 1'b0) begin fails++; $display("FAIL rm_hsync_start: got %b expected 0", vga_hs); end
      av_read(1);
      tests++;
      if (readdata !== 8'h00) begin fails++; $display("FAIL rm_bg_g: got %h expected 00", readdata); end
      av_read(4);
      tests++;
      if (readdata !== 8'h01) begin fails++; $display("FAIL rm_x_hi: got %h expected 01", readdata); end
      av_read(7);
      tests++;
      if (readdata !== 8'h00) begin fails++; $display("FAIL rm_fcount: got %h expected 00", readdata); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         int x, y, tgt, ln, a;
         x = int'($urandom_range(0, 700));
         y = int'($urandom_range(0, 520));
         av_write(0, int'($urandom_range(0, 255)));
         av_write(1, int'($urandom_range(0, 255)));
         av_write(2, int'($urandom_range(0, 255)));
         av_write(3, x % 256);
         av_write(4, int'($urandom_range(0, 63)) * 4 + x / 256);
         av_write(5, y % 256);
         av_write(6, int'($urandom_range(0, 63)) * 4 + y / 256);
         av_write(7, int'($urandom_range(0, 255)));
         a = int'($urandom_range(0, 7));
         av_read(a);
         tests++;
         if (readdata !== 8'(m_rd)) begin
            fails++; $display("FAIL rand_read_%0d: addr %0d got %h expected %h", it, a, readdata, 8'(m_rd));
         end
         goto_line(479);
         run_to("rand_latch", 0, 480);
         tgt = ((y < 480) ? y : 479) + int'($urandom_range(0, 16)) - 8;
         if (tgt < 0) tgt = 0;
         if (tgt > 479) tgt = 479;
         ln = (tgt == 0) ? 524 : tgt - 1;
         goto_line(ln);
         run_to("rand_scan", 1504, tgt);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_timing();
      test_defaults();
      test_write_timing();
      test_latch_write();
      test_frame_count();
      test_reset_midframe();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vga_ball_display.md
# vga_ball_display

Avalon-MM slave peripheral inside `soc_system` that generates the exported `vga_*` pins: a 640x480 @ 60 Hz raster timing generator running from the 50 MHz system clock, drawing a solid-colour background and one white filled circle. The HPS writes background colour and ball position over the lightweight bridge. Writes land in pending registers and are copied to the display registers once per frame at the start of vertical blanking, so the displayed image never tears mid-frame.

## Interface
- `BALL_R`, 16: ball radius in pixels. A pixel is inside when dx²+dy² ≤ BALL_R².
- `clk` in 1: 50 MHz system clock, the only clock.
- `reset_n` in 1: synchronous, active-low reset.
- `chipselect` in 1: Avalon slave select.
- `write` in 1: Avalon write strobe.
- `read` in 1: Avalon read strobe.
- `address` in 3: register index.
- `writedata` in 8: write data.
- `readdata` out 8: read data, registered, valid the cycle after `read`.
- `vga_r`, `vga_g`, `vga_b` out 8 each: pixel colour.
- `vga_clk` out 1: 25 MHz pixel clock, equal to `hcount[0]`.
- `vga_hs` out 1: horizontal sync, active low.
- `vga_vs` out 1: vertical sync, active low.
- `vga_blank_n` out 1: high during the active area.
- `vga_sync_n` out 1: tied to 0.

## Operation
- **Counters.**
  - `hcount` is 11 bits and counts 0..1599, then wraps to 0. Pixel x = `hcount[10:1]`.
  - `vcount` is 10 bits, counts 0..524, and increments when `hcount`=1599. At (1599, 524) it wraps to 0.
- **Horizontal timing, in hcount units.** Active 0..1279, front porch 1280..1311, sync 1312..1503, back porch 1504..1599.
- **Vertical timing, in lines.** Active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- **Sync and blank.**
  - `vga_hs` = 0 when `hcount` is in [1312, 1503]. `vga_vs` = 0 when `vcount` is in [490, 491].
  - `vga_blank_n` = (`hcount` < 1280) && (`vcount` < 480).
- **Register map (write, when `chipselect` && `write`).**
  - Address 0: bg_r. Address 1: bg_g. Address 2: bg_b.
  - Address 3: x[7:0]. Address 4: x[9:8] from `writedata[1:0]`.
  - Address 5: y[7:0]. Address 6: y[9:8] from `writedata[1:0]`.
  - Address 7: read-only; writes are ignored.
- **Read.** When `chipselect` && `read`, `readdata` is updated on the next edge.
  - Addresses 0..6 return the pending value, zero-extended.
  - Address 7 returns `frame_count`.
  - `readdata` holds its value when not reading.
- **Frame latch event.** Occurs on the edge where `hcount`=1599 and `vcount`=479.
  - All pending registers copy to the display registers.
  - `frame_count` (8 bits) increments and wraps 255→0.
- **Write on the latch cycle.** The display registers take the pre-write pending value. The new value appears in the following frame.
- **Colour.**
  - When `vga_blank_n` = 0: RGB = 0.
  - Otherwise, with dx = px − ball_x and dy = vcount − ball_y (signed 11-bit), squares compared at 22-bit width:
    - inside the ball → RGB = FF/FF/FF;
    - else → display bg_r/bg_g/bg_b.
- **Ball clipping.** Ball positions beyond the screen simply clip; there is no wrap-around.
- **Reset values.**
  - Counters: `hcount`=0, `vcount`=0, `frame_count`=0, `readdata`=0.
  - Pending and display registers: bg = 00/00/80, ball = (320, 240).
  - Outputs while `reset_n` is held low (after one edge): `vga_hs`=1, `vga_vs`=1, `vga_blank_n`=1, `vga_clk`=0, `vga_sync_n`=0, RGB = 00/00/80.
- **Reset mid-frame.** Restarts both counters at 0 on the next edge and discards pending writes.

## Timing
- Sync, blank and RGB are combinational from the counters and display registers.
  - Pixel (x, y) is shown during `hcount` = 2x and 2x+1.
  - `vga_clk` rises mid-pixel.
- Line period is 1600 clk (32 µs). Frame period is 840 000 clk (16.8 ms).
- Writes take effect in pending registers on the edge after they are asserted. No wait states.
- Read latency is 1 cycle.
- Display registers change only at the frame latch event.

## Test plan
- **Timing check.** Release reset and run 2 frames.
  - `vga_hs` low for exactly 192 clk every 1600.
  - `vga_vs` low for exactly 2 lines (3200 clk) every 525 lines.
  - `vga_blank_n` high for 1280 clk on each of lines 0..479.
- **Defaults.** After reset, at pixel (0,0) RGB = 00/00/80; at pixel (320,240) RGB = FF/FF/FF.
- **Write timing.** Write bg_r=0x55 while `vcount`=100.
  - RGB stays 00 red for the rest of the frame.
  - From line 0 of the next frame, background red = 0x55.
  - Reading address 0 returns 0x55 one cycle after the read.
- **Write on latch cycle.** Write x_lo on the exact latch cycle. The display keeps the old x for one extra frame, then updates.
- **Frame counter.** Run 256 frames; reading address 7 returns 0 again.
- **Reset mid-frame.** Assert `reset_n`=0 for one cycle at `hcount`=700, `vcount`=300 with a write pending. The next edge shows `hcount`=0, `vcount`=0, and registers back at their reset values.
